// File: rtl/step_pkg.sv
// Shared types and constants for the single-step pulse generator.
// Debounce state encoding, default timing and the step counter width.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned AUTO_DIV_DEF        = 50000000;
  // Same width as the PC so the LEDs show where the core should be.
  localparam int unsigned STEP_CNT_W          = 8;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous level input.
// Clears to 0 on asynchronous active-low reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift the raw level through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced single-step and auto-run step enable for the core.
// Emits one registered step_en pulse per press or per auto-run period.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned AUTO_DIV        = AUTO_DIV_DEF,
  parameter int unsigned CNT_W           =
    $clog2(max_u(DEBOUNCE_CYCLES, AUTO_DIV))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_raw,
  input  logic                  run_mode,
  output logic                  step_en,
  output logic                  sw_db,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  logic                  sw_s;
  logic                  run_s;
  db_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      div_q, div_d;
  logic                  db_q, db_d;
  logic                  en_q;
  logic [STEP_CNT_W-1:0] scnt_q;
  logic                  cnt_last;
  logic                  div_last;
  logic                  man_req;
  logic                  auto_req;
  logic                  step_req;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sw_raw),
    .q_o   (sw_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_run (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (run_mode),
    .q_o   (run_s)
  );

  assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign div_last = (div_q == CNT_W'(AUTO_DIV - 1));

  // Debounce state, stable-count and accepted level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  // Debounce next state from the synchronized switch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE_LOW:  if (sw_s) state_d = WAIT_HIGH;
      WAIT_HIGH: begin
        if (!sw_s)         state_d = IDLE_LOW;
        else if (cnt_last) state_d = HIGH;
      end
      HIGH:      if (!sw_s) state_d = WAIT_LOW;
      WAIT_LOW:  begin
        if (sw_s)          state_d = HIGH;
        else if (cnt_last) state_d = IDLE_LOW;
      end
      default:   state_d = IDLE_LOW;
    endcase
  end

  // Debounce counter, level update and press request.
  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    man_req = 1'b0;
    unique case (state_q)
      IDLE_LOW:  cnt_d = '0;
      WAIT_HIGH: begin
        if (sw_s && cnt_last) begin
          cnt_d   = '0;
          db_d    = 1'b1;
          man_req = 1'b1;
        end else if (sw_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH:      cnt_d = '0;
      WAIT_LOW:  begin
        if (!sw_s && cnt_last) begin
          cnt_d = '0;
          db_d  = 1'b0;
        end else if (!sw_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default:   cnt_d = '0;
    endcase
  end

  // Auto-run divider; held at zero outside run mode.
  always_comb begin
    div_d = '0;
    if (run_s && !div_last) begin
      div_d = div_q + CNT_W'(1);
    end
  end

  assign auto_req = run_s & div_last;
  // Run mode owns the step source; presses only move sw_db.
  assign step_req = run_s ? auto_req : man_req;

  // Divider, step pulse and step counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      en_q   <= 1'b0;
      scnt_q <= '0;
    end else begin
      div_q  <= div_d;
      en_q   <= step_req;
      scnt_q <= scnt_q + STEP_CNT_W'(step_req);
    end
  end

  assign step_en  = en_q;
  assign sw_db    = db_q;
  assign step_cnt = scnt_q;

endmodule
